hyper_phy_arbiter: RTL and testbench



---
 rtl/hyper_phy_arbiter.sv | 168 ++++++++++++++++
 tb/tb_hyper_phy_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_phy_arbiter.sv
// Two-requester arbiter for the shared HyperBus PHY. It grants round-robin,
// holds the grant for one whole transaction, enforces a CS-high gap between
// PHY transactions, and aborts any transaction whose completion never arrives.
module hyper_phy_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int CS_GAP  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LEN_W-1:0]  req0_len_i,
  input  logic              req0_we_i,
  input  logic              req0_cs_i,
  output logic              req0_done_o,
  output logic              req0_err_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LEN_W-1:0]  req1_len_i,
  input  logic              req1_we_i,
  input  logic              req1_cs_i,
  output logic              req1_done_o,
  output logic              req1_err_o,
  output logic              phy_valid_o,
  input  logic              phy_ready_i,
  output logic [ADDR_W-1:0] phy_addr_o,
  output logic [LEN_W-1:0]  phy_len_o,
  output logic              phy_we_o,
  output logic              phy_cs_o,
  input  logic              phy_done_i,
  output logic              phy_abort_o,
  output logic              busy_o,
  output logic              owner_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  logic [1:0]        state;
  logic              rr_ptr;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap_cnt;
  logic              done_r;
  logic              err_r;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_we;
  logic              cmd_cs;

  logic              winner;
  logic              accept;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic              win_we;
  logic              win_cs;
  logic              timeout_hit;

  // Pick the winner (single valid wins, otherwise rr_ptr) and mux its command.
  always_comb begin
    winner = rr_ptr;
    if (req0_valid_i && !req1_valid_i) begin
      winner = 1'b0;
    end else if (!req0_valid_i && req1_valid_i) begin
      winner = 1'b1;
    end
    accept   = (state == S_IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
    win_addr = winner ? req1_addr_i : req0_addr_i;
    win_len  = winner ? req1_len_i  : req0_len_i;
    win_we   = winner ? req1_we_i   : req0_we_i;
    win_cs   = winner ? req1_cs_i   : req0_cs_i;
  end

  assign req0_ready_o = accept && !winner;
  assign req1_ready_o = accept && winner;

  // A completion arriving on the last allowed cycle takes priority over abort.
  assign timeout_hit = (state == S_WAIT) && (timer == TMR_W'(TIMEOUT - 1));
  assign phy_abort_o = timeout_hit && !phy_done_i;

  assign phy_valid_o = (state == S_ISSUE);
  assign phy_addr_o  = cmd_addr;
  assign phy_len_o   = cmd_len;
  assign phy_we_o    = cmd_we;
  assign phy_cs_o    = cmd_cs;
  assign busy_o      = (state != S_IDLE);

  // Completion pulses are routed only to the requester that owns the grant.
  assign req0_done_o = done_r && !owner_o;
  assign req1_done_o = done_r && owner_o;
  assign req0_err_o  = err_r && !owner_o;
  assign req1_err_o  = err_r && owner_o;

  // Transaction sequencer: arbitration, PHY handshake, watchdog and CS gap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      rr_ptr   <= 1'b0;
      owner_o  <= 1'b0;
      timer    <= '0;
      gap_cnt  <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      cmd_addr <= '0;
      cmd_len  <= '0;
      cmd_we   <= 1'b0;
      cmd_cs   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cmd_addr <= win_addr;
            cmd_len  <= win_len;
            cmd_we   <= win_we;
            cmd_cs   <= win_cs;
            owner_o  <= winner;
            rr_ptr   <= ~winner;
            // Zero-length commands are rejected without touching the PHY.
            if (win_len == '0) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (phy_ready_i) begin
            state <= S_WAIT;
            timer <= '0;
          end
        end
        S_WAIT: begin
          if (phy_done_i) begin
            done_r  <= 1'b1;
            state   <= S_GAP;
            gap_cnt <= GAP_W'(CS_GAP - 1);
          end else if (timeout_hit) begin
            done_r  <= 1'b1;
            err_r   <= 1'b1;
            state   <= S_GAP;
            gap_cnt <= GAP_W'(CS_GAP - 1);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_phy_arbiter.sv
// Randomized bench for hyper_phy_arbiter. A transaction-level model predicts
// the winner from the round-robin rule and the cycle-by-cycle timeline from
// the chosen PHY ready/done delays.
module tb_hyper_phy_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 16;
  localparam int CS_GAP  = 4;
  localparam int TIMEOUT = 64;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req0_valid_i = 1'b0;
  logic              req0_ready_o;
  logic [ADDR_W-1:0] req0_addr_i = '0;
  logic [LEN_W-1:0]  req0_len_i = '0;
  logic              req0_we_i = 1'b0;
  logic              req0_cs_i = 1'b0;
  logic              req0_done_o;
  logic              req0_err_o;
  logic              req1_valid_i = 1'b0;
  logic              req1_ready_o;
  logic [ADDR_W-1:0] req1_addr_i = '0;
  logic [LEN_W-1:0]  req1_len_i = '0;
  logic              req1_we_i = 1'b0;
  logic              req1_cs_i = 1'b0;
  logic              req1_done_o;
  logic              req1_err_o;
  logic              phy_valid_o;
  logic              phy_ready_i = 1'b0;
  logic [ADDR_W-1:0] phy_addr_o;
  logic [LEN_W-1:0]  phy_len_o;
  logic              phy_we_o;
  logic              phy_cs_o;
  logic              phy_done_i = 1'b0;
  logic              phy_abort_o;
  logic              busy_o;
  logic              owner_o;

  logic [1:0] done_v;
  logic [1:0] err_v;
  assign done_v = {req1_done_o, req0_done_o};
  assign err_v  = {req1_err_o, req0_err_o};

  hyper_phy_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_addr_i(req0_addr_i), .req0_len_i(req0_len_i),
    .req0_we_i(req0_we_i), .req0_cs_i(req0_cs_i),
    .req0_done_o(req0_done_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_addr_i(req1_addr_i), .req1_len_i(req1_len_i),
    .req1_we_i(req1_we_i), .req1_cs_i(req1_cs_i),
    .req1_done_o(req1_done_o), .req1_err_o(req1_err_o),
    .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i),
    .phy_addr_o(phy_addr_o), .phy_len_o(phy_len_o),
    .phy_we_o(phy_we_o), .phy_cs_o(phy_cs_o),
    .phy_done_i(phy_done_i), .phy_abort_o(phy_abort_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  bit exp_rr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outputs that must hold in every cycle of an ongoing transaction.
  task automatic chk_busy(input string tag, input bit owner, input bit pv, input bit ab);
    chk({tag, "_busy"}, busy_o, 1'b1);
    chk({tag, "_rdy"}, {req1_ready_o, req0_ready_o}, 2'b00);
    chk({tag, "_owner"}, owner_o, owner);
    chk({tag, "_pvalid"}, phy_valid_o, pv);
    chk({tag, "_abort"}, phy_abort_o, ab);
  endtask

  // One command from offer to the first idle cycle. done_k: WAIT cycle
  // (1-based) in which the PHY reports completion, 0 means never.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                        input bit we0, input bit we1, input bit cs0, input bit cs1,
                        input int rdly, input int done_k, input bit keep_loser,
                        input bit spur);
    bit win;
    bit to;
    logic [1:0] mask;
    logic [ADDR_W-1:0] ea;
    logic [LEN_W-1:0] el;
    bit ewe, ecs;
    win  = (v0 && v1) ? exp_rr : v1;
    mask = win ? 2'b10 : 2'b01;
    ea   = win ? a1 : a0;
    el   = win ? l1 : l0;
    ewe  = win ? we1 : we0;
    ecs  = win ? cs1 : cs0;
    req0_valid_i = v0; req0_addr_i = a0; req0_len_i = l0; req0_we_i = we0; req0_cs_i = cs0;
    req1_valid_i = v1; req1_addr_i = a1; req1_len_i = l1; req1_we_i = we1; req1_cs_i = cs1;
    phy_done_i  = spur ? 1'($urandom) : 1'b0;
    phy_ready_i = spur ? 1'($urandom) : 1'b0;
    #1;
    chk("idle_ready0", req0_ready_o, v0 && !win);
    chk("idle_ready1", req1_ready_o, v1 && win);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_pvalid", phy_valid_o, 1'b0);
    @(negedge clk_i);
    exp_rr = !win;
    phy_done_i = 1'b0; phy_ready_i = 1'b0;
    if (!(keep_loser && v0 && v1) || el == '0) begin
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    end else if (win) begin
      req1_valid_i = 1'b0;
    end else begin
      req0_valid_i = 1'b0;
    end
    #1;
    chk("acc_owner", owner_o, win);
    if (el == '0) begin
      chk("zl_done", done_v, mask);
      chk("zl_err", err_v, mask);
      chk("zl_busy", busy_o, 1'b0);
      chk("zl_pvalid", phy_valid_o, 1'b0);
      return;
    end
    // ISSUE: command held stable until the PHY handshake.
    for (int i = 0; i <= rdly; i++) begin
      chk_busy("issue", win, 1'b1, 1'b0);
      chk("issue_addr", phy_addr_o, ea);
      chk("issue_len", phy_len_o, el);
      chk("issue_we", phy_we_o, ewe);
      chk("issue_cs", phy_cs_o, ecs);
      chk("issue_done", done_v, 2'b00);
      phy_ready_i = (i == rdly);
      if (spur) phy_done_i = 1'($urandom);
      @(negedge clk_i);
      phy_ready_i = 1'b0; phy_done_i = 1'b0;
      #1;
    end
    // WAIT: watchdog counts TIMEOUT cycles unless completion arrives.
    to = 1'b1;
    for (int w = 1; w <= TIMEOUT; w++) begin
      bit dn;
      dn = (done_k == w);
      phy_done_i = dn;
      if (spur) phy_ready_i = 1'($urandom);
      #1;
      chk_busy("wait", win, 1'b0, (w == TIMEOUT) && !dn);
      chk("wait_done", done_v, 2'b00);
      @(negedge clk_i);
      phy_done_i = 1'b0; phy_ready_i = 1'b0;
      #1;
      if (dn) begin
        to = 1'b0;
        break;
      end
    end
    chk("gap_done", done_v, mask);
    chk("gap_err", err_v, to ? mask : 2'b00);
    // GAP: exactly CS_GAP busy cycles before returning to idle.
    for (int g = 1; g <= CS_GAP; g++) begin
      chk_busy("gap", win, 1'b0, 1'b0);
      if (g > 1) chk("gap_nodone", done_v, 2'b00);
      if (spur) begin
        phy_done_i = 1'($urandom); phy_ready_i = 1'($urandom);
      end
      @(negedge clk_i);
      phy_done_i = 1'b0; phy_ready_i = 1'b0;
      #1;
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    #1;
    chk("end_busy", busy_o, 1'b0);
    chk("end_done", done_v, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state, with requesters valid to prove readys are forced low.
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_rdy", {req1_ready_o, req0_ready_o}, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_pvalid", phy_valid_o, 1'b0);
    chk("rst_addr", phy_addr_o, '0);
    chk("rst_done", {done_v, err_v}, 4'b0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rst_i = 1'b0;
    exp_rr = 1'b0;

    // Dual requests alternate from req0.
    for (int i = 0; i < 6; i++)
      do_txn(1, 1, $urandom, $urandom, LEN_W'(i + 1), LEN_W'(i + 9), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), i % 3, 3 + i, 1, 0);
    // Single request with fixed fields and timing.
    do_txn(1, 0, 32'h1000, 32'h0, 16'd16, 16'd0, 1, 0, 0, 0, 2, 5, 0, 0);
    // Watchdog abort on req1.
    do_txn(0, 1, 32'h0, 32'h2222, 16'd0, 16'd4, 0, 1, 0, 1, 1, 0, 0, 0);
    // Zero-length then a dual request.
    do_txn(1, 0, 32'h40, 32'h0, 16'd0, 16'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_txn(1, 1, 32'h50, 32'h60, 16'd2, 16'd3, 0, 1, 1, 0, 0, 2, 0, 0);
    // Completion on the exact timeout cycle.
    do_txn(1, 0, 32'h70, 32'h0, 16'd1, 16'd0, 1, 0, 0, 0, 0, TIMEOUT, 0, 0);

    // Reset during WAIT.
    req1_valid_i = 1'b1; req1_len_i = 16'd8; req1_addr_i = 32'hABCD;
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    phy_ready_i = 1'b1;
    @(negedge clk_i);
    phy_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_out", {phy_valid_o, phy_abort_o, owner_o, req0_ready_o, req1_ready_o},
        5'b0);
    chk("mrst_done", {done_v, err_v}, 4'b0);
    chk("mrst_addr", phy_addr_o, '0);
    @(negedge clk_i);
    #1;
    chk("mrst_hold", {busy_o, phy_valid_o, done_v, err_v}, 6'b0);
    rst_i = 1'b0;
    exp_rr = 1'b0;
    do_txn(1, 1, 32'h11, 32'h22, 16'd5, 16'd6, 0, 0, 0, 0, 1, 3, 1, 1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int sel, r, dk;
      sel = $urandom_range(1, 3);
      r = $urandom_range(0, 7);
      dk = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 12);
      do_txn(sel[0], sel[1], $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(1, 65535)),
             ($urandom_range(0, 7) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(1, 65535)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), dk, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
